// File: rtl/forward_source_pipe_pkg.sv
// Shared types for the forwarding data path: select codes, FSM states,
// the per-stage slot record and a saturating counter helper.
package forward_source_pipe_pkg;

    localparam int SLOT_DATA_W = 32;
    localparam int SLOT_REG_AW = 5;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXE     = 2'd1;
    localparam logic [1:0] FWD_MEM     = 2'd2;
    localparam logic [1:0] FWD_WB      = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD_BUBBLE,
        ST_MEM_WAIT
    } fsm_state_t;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_REG_AW-1:0] dest;
        logic                   is_load;
        logic [SLOT_DATA_W-1:0] value;
    } slot_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] cnt,
        input logic [1:0]  inc
    );
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'd0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/forward_source_pipe_if.sv
// Bundle between the ID/EXE/MEM pipeline and the forwarding data path.
// master = pipeline side, slave = forward_source_pipe.
interface forward_source_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ID_Dest;
    logic              ID_WriteEn;
    logic              ID_IsLoad;
    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic              ID_UsesRt;
    logic [DATA_W-1:0] EXE_Result;
    logic [DATA_W-1:0] MEM_LoadData;
    logic              MEM_Ready;
    logic [1:0]        EXE_A_Select;
    logic [1:0]        EXE_B_Select;
    logic [1:0]        MEM_Data_Select;
    logic [DATA_W-1:0] Alt_RegA;
    logic [DATA_W-1:0] Alt_RegB;
    logic [DATA_W-1:0] Alt_MEM_Data;
    logic              Alt_A_Valid;
    logic              Alt_B_Valid;
    logic              Alt_MEM_Valid;
    logic              stall;
    logic              mem_hold;

    modport master (
        output ID_Dest, ID_WriteEn, ID_IsLoad,
        output ID_Rs, ID_Rt, ID_UsesRt,
        output EXE_Result, MEM_LoadData, MEM_Ready,
        output EXE_A_Select, EXE_B_Select, MEM_Data_Select,
        input  Alt_RegA, Alt_RegB, Alt_MEM_Data,
        input  Alt_A_Valid, Alt_B_Valid, Alt_MEM_Valid,
        input  stall, mem_hold
    );

    modport slave (
        input  ID_Dest, ID_WriteEn, ID_IsLoad,
        input  ID_Rs, ID_Rt, ID_UsesRt,
        input  EXE_Result, MEM_LoadData, MEM_Ready,
        input  EXE_A_Select, EXE_B_Select, MEM_Data_Select,
        output Alt_RegA, Alt_RegB, Alt_MEM_Data,
        output Alt_A_Valid, Alt_B_Valid, Alt_MEM_Valid,
        output stall, mem_hold
    );

endinterface

// File: rtl/forward_source_pipe_select.sv
// fwd_select_mux: resolves one select code against the EXE/MEM/WB slots.
// An unusable source yields zero so the consumer keeps the regfile value.
module fwd_select_mux
    import forward_source_pipe_pkg::*;
#(
    parameter int DATA_W = SLOT_DATA_W
) (
    input  logic [1:0]        sel,
    input  slot_t             exe_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alt,
    output logic              valid
);

    logic [DATA_W-1:0] data;
    logic              hit;
    logic              unused_exe_value;

    // EXE data always comes live from the ALU, never from the slot
    assign unused_exe_value = ^exe_slot.value;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        unique case (sel)
            FWD_REGFILE: ;
            FWD_EXE: begin
                hit  = exe_slot.valid && !exe_slot.is_load
                    && exe_slot.dest != '0;
                data = exe_result;
            end
            FWD_MEM: begin
                hit  = mem_slot.valid && mem_slot.dest != '0
                    && (!mem_slot.is_load || mem_ready);
                data = mem_slot.is_load ? mem_load_data
                                        : mem_slot.value;
            end
            FWD_WB: begin
                hit  = wb_slot.valid && wb_slot.dest != '0;
                data = wb_slot.value;
            end
            default: ;
        endcase
        valid = hit;
        alt   = hit ? data : '0;
    end

endmodule

// File: rtl/forward_source_pipe.sv
// Forwarding data path: EXE/MEM/WB tag slots, select resolution, load-use
// bubble and memory-wait hold. Optional counters under `FWD_STATS_EN.
module forward_source_pipe
    import forward_source_pipe_pkg::*;
#(
    parameter int DATA_W = SLOT_DATA_W,
    parameter int REG_AW = SLOT_REG_AW
) (
    input  logic                 CLK,
    input  logic                 RESET,
    forward_source_pipe_if.slave fwd
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]          fwd_count,
    output logic [31:0]          loaduse_count,
    output logic [31:0]          memwait_count
`endif
);

    slot_t      exe_q, mem_q, wb_q;
    slot_t      exe_d, mem_d, wb_d;
    fsm_state_t state_q, state_d;
    logic       wait_c, hazard, load_use;

    always_comb begin
        wait_c = mem_q.valid && mem_q.is_load && !fwd.MEM_Ready;
        hazard = exe_q.valid && exe_q.is_load
            && (fwd.ID_Rs == exe_q.dest
                || (fwd.ID_UsesRt && fwd.ID_Rt == exe_q.dest));
        load_use = (state_q == ST_RUN) && hazard && !wait_c;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:
                if (wait_c)      state_d = ST_MEM_WAIT;
                else if (hazard) state_d = ST_LOAD_BUBBLE;
            ST_LOAD_BUBBLE:
                state_d = wait_c ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT:
                state_d = wait_c ? ST_MEM_WAIT : ST_RUN;
            default:
                state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fwd.mem_hold = wait_c;
        fwd.stall    = wait_c || load_use;
    end

    // A load's data is captured as it leaves MEM, whether or not it waited
    always_comb begin
        mem_d       = exe_q;
        mem_d.value = fwd.EXE_Result;
        wb_d        = mem_q;
        if (mem_q.is_load) wb_d.value = fwd.MEM_LoadData;
        exe_d = '0;
        if (!load_use) begin
            exe_d.valid   = fwd.ID_WriteEn
                && fwd.ID_Dest != REG_AW'(0);
            exe_d.dest    = fwd.ID_Dest;
            exe_d.is_load = fwd.ID_IsLoad;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!wait_c) begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    fwd_select_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel          (fwd.EXE_A_Select),
        .exe_slot     (exe_q),
        .mem_slot     (mem_q),
        .wb_slot      (wb_q),
        .exe_result   (fwd.EXE_Result),
        .mem_load_data(fwd.MEM_LoadData),
        .mem_ready    (fwd.MEM_Ready),
        .alt          (fwd.Alt_RegA),
        .valid        (fwd.Alt_A_Valid)
    );

    fwd_select_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel          (fwd.EXE_B_Select),
        .exe_slot     (exe_q),
        .mem_slot     (mem_q),
        .wb_slot      (wb_q),
        .exe_result   (fwd.EXE_Result),
        .mem_load_data(fwd.MEM_LoadData),
        .mem_ready    (fwd.MEM_Ready),
        .alt          (fwd.Alt_RegB),
        .valid        (fwd.Alt_B_Valid)
    );

    fwd_select_mux #(.DATA_W(DATA_W)) u_mux_m (
        .sel          (fwd.MEM_Data_Select),
        .exe_slot     (exe_q),
        .mem_slot     (mem_q),
        .wb_slot      (wb_q),
        .exe_result   (fwd.EXE_Result),
        .mem_load_data(fwd.MEM_LoadData),
        .mem_ready    (fwd.MEM_Ready),
        .alt          (fwd.Alt_MEM_Data),
        .valid        (fwd.Alt_MEM_Valid)
    );

`ifdef FWD_STATS_EN
    logic [1:0] n_fwd;

    always_comb begin
        n_fwd = {1'b0, fwd.Alt_A_Valid}
              + {1'b0, fwd.Alt_B_Valid}
              + {1'b0, fwd.Alt_MEM_Valid};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fwd_count     <= '0;
            loaduse_count <= '0;
            memwait_count <= '0;
        end else begin
            fwd_count     <= sat_inc(fwd_count, n_fwd);
            loaduse_count <= sat_inc(loaduse_count, {1'b0, load_use});
            memwait_count <= sat_inc(memwait_count, {1'b0, wait_c});
        end
    end
`endif

endmodule
